inst_encoder_loader: RTL and testbench

- Program-load front end for the core's instruction memory: accepts instruction commands as fields (ALU op, registers, immediate) over a valid/ready handshake.
- Encodes each command into the 32-bit instruction format the pipeline decode stage consumes, zero-extended to DATAPATH_WIDTH.
- Writes encoded words into instruction memory at consecutive addresses from a programmable base.
- Sits between the host/packet-side control path and the per-core instruction RAM write port.

---
 rtl/inst_isa_pkg.sv | 48 ++++
 rtl/inst_word_encoder.sv | 42 ++++
 rtl/inst_encoder_loader.sv | 105 ++++++++++
 tb/tb_inst_encoder_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_isa_pkg.sv
// Instruction-format constants shared by the program loader and the decode stage.
package inst_isa_pkg;

  localparam int INST_W = 32;
  localparam int REG_W  = 5;

  // Field LSB positions of the 32-bit instruction word.
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SHIFT = 6'b001100;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOT   = 6'b100111;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SHA   = 6'b100000;
  localparam logic [5:0] FN_SHB   = 6'b000001;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SHA = 4'd6;
  localparam logic [3:0] ALU_SHB = 4'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL} load_state_e;

  function automatic logic [INST_W-1:0] pack_rtype(
    input logic [5:0]       op,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd,
    input logic [5:0]       fn
  );
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

endpackage

// File: rtl/inst_word_encoder.sv
// Combinational command-field to instruction-word encoder with illegal-command detect.
module inst_word_encoder
  import inst_isa_pkg::*;
(
  input  logic              nop,
  input  logic              imm,
  input  logic [3:0]        alu_ctrl,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [10:0]       imm11,
  output logic [INST_W-1:0] word,
  output logic              illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    if (nop && imm) begin
      illegal = 1'b1;
    end else if (nop) begin
      word = '0;
    end else if (imm) begin
      // ADDI carries rd in [15:11], which leaves only 11 immediate bits.
      if (alu_ctrl == ALU_ADD) word = {OP_ADDI, rs, {REG_W{1'b0}}, rd, imm11};
      else                     illegal = 1'b1;
    end else begin
      case (alu_ctrl)
        ALU_ADD: word = pack_rtype(OP_RTYPE, rs, rt, rd, FN_ADD);
        ALU_SUB: word = pack_rtype(OP_RTYPE, rs, rt, rd, FN_SUB);
        ALU_AND: word = pack_rtype(OP_RTYPE, rs, rt, rd, FN_AND);
        ALU_OR:  word = pack_rtype(OP_RTYPE, rs, rt, rd, FN_OR);
        ALU_NOT: word = pack_rtype(OP_RTYPE, rs, rt, rd, FN_NOT);
        ALU_XOR: word = pack_rtype(OP_RTYPE, rs, rt, rd, FN_XOR);
        ALU_SHA: word = pack_rtype(OP_SHIFT, rs, rt, rd, FN_SHA);
        ALU_SHB: word = pack_rtype(OP_SHIFT, rs, rt, rd, FN_SHB);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program-load front end: encodes commands and writes them to instruction memory
// at consecutive addresses from a programmable base.
module inst_encoder_loader
  import inst_isa_pkg::*;
#(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = REG_W,
  parameter int INST_ADDR_WIDTH    = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [INST_ADDR_WIDTH-1:0]    base_addr,
  input  logic                          finish,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_nop,
  input  logic                          cmd_imm,
  input  logic [3:0]                    cmd_alu_ctrl,
  input  logic [REGFILE_ADDR_WIDTH-1:0] cmd_rs,
  input  logic [REGFILE_ADDR_WIDTH-1:0] cmd_rt,
  input  logic [REGFILE_ADDR_WIDTH-1:0] cmd_rd,
  input  logic [10:0]                   cmd_imm11,
  output logic                          imem_we,
  output logic [INST_ADDR_WIDTH-1:0]    imem_addr,
  output logic [DATAPATH_WIDTH-1:0]     imem_wdata,
  output logic                          loading,
  output logic                          full,
  output logic                          err_illegal,
  output logic [INST_ADDR_WIDTH:0]      prog_len
);

  localparam logic [INST_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [INST_ADDR_WIDTH:0]   LEN_MAX  = {1'b1, {INST_ADDR_WIDTH{1'b0}}};

  load_state_e                state, state_nxt;
  logic [INST_ADDR_WIDTH-1:0] addr_cnt;
  logic [INST_W-1:0]          enc_word;
  logic                       enc_illegal;
  logic                       accept, wr_acc;

  inst_word_encoder u_enc (
    .nop      (cmd_nop),
    .imm      (cmd_imm),
    .alu_ctrl (cmd_alu_ctrl),
    .rs       (cmd_rs),
    .rt       (cmd_rt),
    .rd       (cmd_rd),
    .imm11    (cmd_imm11),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  assign cmd_ready = (state == ST_LOAD) & ~start & ~finish;
  assign accept    = cmd_valid & cmd_ready;
  assign wr_acc    = accept & ~enc_illegal;
  assign loading   = (state == ST_LOAD);
  assign full      = (state == ST_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (start)                                state_nxt = ST_LOAD;
        else if (finish)                          state_nxt = ST_IDLE;
        else if (wr_acc && addr_cnt == ADDR_MAX)  state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (start)       state_nxt = ST_LOAD;
        else if (finish) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_cnt    <= '0;
      prog_len    <= '0;
      err_illegal <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= wr_acc;
      if (start) begin
        addr_cnt    <= base_addr;
        prog_len    <= '0;
        err_illegal <= 1'b0;
      end else if (wr_acc) begin
        imem_addr  <= addr_cnt;
        imem_wdata <= {{(DATAPATH_WIDTH-INST_W){1'b0}}, enc_word};
        // The last address is written once and then the block parks in FULL.
        if (addr_cnt != ADDR_MAX) addr_cnt <= addr_cnt + 1'b1;
        if (prog_len != LEN_MAX)  prog_len <= prog_len + 1'b1;
      end else if (accept) begin
        err_illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader with a behavioural reference model.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, finish, cmd_valid, cmd_nop, cmd_imm;
  logic [8:0]  base_addr;
  logic [3:0]  cmd_alu_ctrl;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [10:0] cmd_imm11;
  logic        cmd_ready, imem_we, loading, full, err_illegal;
  logic [8:0]  imem_addr;
  logic [63:0] imem_wdata;
  logic [9:0]  prog_len;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  inst_encoder_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_nop(cmd_nop), .cmd_imm(cmd_imm),
    .cmd_alu_ctrl(cmd_alu_ctrl), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm11(cmd_imm11), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .loading(loading), .full(full),
    .err_illegal(err_illegal), .prog_len(prog_len)
  );

  // Reference encoding from the field table: returns {illegal, word}.
  function automatic logic [32:0] m_enc(input logic nop, input logic imm,
      input int ctrl, input int rs, input int rt, input int rd, input int imm11);
    int fn_tab[6] = '{32, 34, 36, 37, 39, 38};
    longint w;
    if (nop && imm) return {1'b1, 32'd0};
    if (nop) return 33'd0;
    if (imm) begin
      if (ctrl != 0) return {1'b1, 32'd0};
      w = 8 * (64'd1 << 26) + rs * (64'd1 << 21) + rd * (64'd1 << 11) + imm11;
      return {1'b0, 32'(w)};
    end
    if (ctrl > 7) return {1'b1, 32'd0};
    w = rs * (64'd1 << 21) + rt * (64'd1 << 16) + rd * (64'd1 << 11);
    if (ctrl <= 5)      w = w + fn_tab[ctrl];
    else if (ctrl == 6) w = w + 12 * (64'd1 << 26) + 32;
    else                w = w + 12 * (64'd1 << 26) + 1;
    return {1'b0, 32'(w)};
  endfunction

  // Model state: 0 idle, 1 loading, 2 full.
  int          m_st = 0;
  int          m_cnt = 0, m_len = 0;
  bit          m_err = 0, m_we = 0;
  int          m_addr = 0;
  logic [63:0] m_data = '0;
  bit          m_ready;

  assign m_ready = (m_st == 1) && !start && !finish;

  always @(posedge clk) begin
    logic [32:0] e;
    int st, cnt, len, addr;
    bit err, we;
    logic [63:0] data;
    st = m_st; cnt = m_cnt; len = m_len; err = m_err; addr = m_addr; data = m_data; we = 0;
    if (reset) begin
      st = 0; cnt = 0; len = 0; err = 0; addr = 0; data = '0;
      armed <= 1'b1;
    end else if (start) begin
      st = 1; cnt = int'(base_addr); len = 0; err = 0;
    end else if (finish && st != 0) begin
      st = 0;
    end else if (st == 1 && cmd_valid) begin
      e = m_enc(cmd_nop, cmd_imm, int'(cmd_alu_ctrl), int'(cmd_rs), int'(cmd_rt),
                int'(cmd_rd), int'(cmd_imm11));
      if (e[32]) err = 1;
      else begin
        we = 1; addr = cnt; data = {32'd0, e[31:0]};
        if (cnt == 511) st = 2; else cnt = cnt + 1;
        if (len < 512) len = len + 1;
      end
    end
    m_st <= st; m_cnt <= cnt; m_len <= len; m_err <= err;
    m_we <= we; m_addr <= addr; m_data <= data;
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !reset) begin
      cmp("m.cmd_ready", longint'(cmd_ready), longint'(m_ready));
      cmp("m.imem_we", longint'(imem_we), longint'(m_we));
      cmp("m.imem_addr", longint'(imem_addr), longint'(m_addr));
      cmp("m.imem_wdata", longint'(imem_wdata), longint'(m_data));
      cmp("m.loading", longint'(loading), longint'(m_st == 1));
      cmp("m.full", longint'(full), longint'(m_st == 2));
      cmp("m.err_illegal", longint'(err_illegal), longint'(m_err));
      cmp("m.prog_len", longint'(prog_len), longint'(m_len));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input bit nop, input bit imm, input int ctrl,
                         input int rs, input int rt, input int rd, input int imm11);
    cmd_nop = nop; cmd_imm = imm; cmd_alu_ctrl = 4'(ctrl);
    cmd_rs = 5'(rs); cmd_rt = 5'(rt); cmd_rd = 5'(rd); cmd_imm11 = 11'(imm11);
  endtask

  task automatic send(input bit nop, input bit imm, input int ctrl,
                      input int rs, input int rt, input int rd, input int imm11);
    set_cmd(nop, imm, ctrl, rs, rt, rd, imm11);
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic do_start(input int base);
    start = 1'b1; base_addr = 9'(base);
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; finish = 0; cmd_valid = 0; base_addr = '0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    cmp("rst.we", imem_we, 0);
    cmp("rst.addr", imem_addr, 0);
    cmp("rst.wdata", imem_wdata, 0);
    cmp("rst.prog_len", prog_len, 0);
    cmp("rst.ready", cmd_ready, 0);
    cmp("rst.loading", loading, 0);

    // Model self-pin against hand-computed words.
    cmp("pin.add", longint'(m_enc(0, 0, 0, 1, 2, 3, 0)), 64'h00221820);
    cmp("pin.addi", longint'(m_enc(0, 1, 0, 4, 0, 5, 'h07F)), 64'h2080287F);
    cmp("pin.sh7", longint'(m_enc(0, 0, 7, 1, 2, 3, 0)), 64'h30221801);

    // Basic ADD at base 0x010.
    do_start('h010);
    cmp("ld.loading", loading, 1);
    send(0, 0, 0, 1, 2, 3, 0);
    cmp("add.we", imem_we, 1);
    cmp("add.addr", imem_addr, 'h010);
    cmp("add.wdata", imem_wdata, 'h00221820);
    cmp("add.len", prog_len, 1);

    // ADDI then shift op back-to-back, then NOP.
    do_start('h020);
    set_cmd(0, 1, 0, 4, 0, 5, 'h07F);
    cmd_valid = 1'b1;
    cyc();
    cmp("addi.addr", imem_addr, 'h020);
    cmp("addi.wdata", imem_wdata, 'h2080287F);
    set_cmd(0, 0, 7, 1, 2, 3, 0);
    cyc();
    cmd_valid = 1'b0;
    cmp("sh7.we", imem_we, 1);
    cmp("sh7.addr", imem_addr, 'h021);
    cmp("sh7.wdata", imem_wdata, 'h30221801);
    send(1, 0, 3, 7, 7, 7, 'h3FF);
    cmp("nop.we", imem_we, 1);
    cmp("nop.wdata", imem_wdata, 0);
    send(0, 0, 1, 9, 10, 11, 0);
    send(0, 0, 5, 31, 0, 17, 0);
    send(0, 0, 6, 2, 4, 8, 0);

    // Illegal command: consumed, no write, sticky error.
    send(0, 0, 9, 1, 1, 1, 0);
    cmp("ill.we", imem_we, 0);
    cmp("ill.err", err_illegal, 1);
    cmp("ill.len", prog_len, 6);
    send(0, 1, 2, 1, 1, 1, 5);
    send(1, 1, 0, 0, 0, 0, 0);
    cmp("ill2.len", prog_len, 6);
    send(0, 0, 2, 6, 7, 8, 0);
    cmp("ill.next_addr", imem_addr, 'h026);
    cmp("ill.err_hold", err_illegal, 1);
    do_start('h030);
    cmp("ill.err_clr", err_illegal, 0);
    cmp("ill.len_clr", prog_len, 0);

    // Top of memory: two writes then FULL, third command held.
    do_start('h1FE);
    set_cmd(0, 0, 3, 1, 2, 3, 0);
    cmd_valid = 1'b1;
    cyc();
    cmp("full.a0", imem_addr, 'h1FE);
    cyc();
    cmp("full.a1", imem_addr, 'h1FF);
    cmp("full.full", full, 1);
    cmp("full.ready", cmd_ready, 0);
    cyc();
    cmp("full.held_we", imem_we, 0);
    cmp("full.len", prog_len, 2);
    cmd_valid = 1'b0;
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    cmp("full.fin", full, 0);

    // start during a pending command: no accept, counter reloads.
    do_start('h040);
    send(0, 0, 0, 1, 1, 1, 0);
    set_cmd(0, 0, 4, 3, 0, 2, 0);
    cmd_valid = 1'b1; start = 1'b1; base_addr = 9'h050;
    #1;
    cmp("st.ready", cmd_ready, 0);
    cyc();
    start = 1'b0;
    cmp("st.no_we", imem_we, 0);
    cyc();
    cmd_valid = 1'b0;
    cmp("st.addr", imem_addr, 'h050);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    cmp("fin.loading", loading, 0);
    cmp("fin.ready", cmd_ready, 0);

    // Reset right after an accept.
    do_start('h060);
    send(0, 0, 5, 1, 2, 3, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cmp("rr.we", imem_we, 0);
    cmp("rr.addr", imem_addr, 0);
    cmp("rr.wdata", imem_wdata, 0);
    cmp("rr.len", prog_len, 0);
    cmp("rr.loading", loading, 0);
    cyc();
    cmp("rr.we2", imem_we, 0);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
